cic_decim_integrator_cascade: RTL
=================================

# cic_decim_integrator_cascade

Parametrised integrator section for the CIC decimator: a cascade of NUM_STAGES registered integrators applied in parallel to NUM_CHAN sample lanes, with input sign extension to the CIC register width and a decimation-phase marker for the downstream comb section. It sits between the front-end sample source and the decimating comb. It replaces hand-chained single-stage I/Q integrators with one block whose valid-gapped pipeline, synchronous flush and phase tagging are defined once.

## Interface
- NUM_CHAN, 2: number of parallel lanes (2 = I/Q).
- NUM_STAGES, 4: integrator stages N (1..8).
- IN_WIDTH, 16: input sample width, two's complement.
- OUT_WIDTH, 40: accumulator/output width. Must satisfy OUT_WIDTH ≥ IN_WIDTH + NUM_STAGES·ceil(log2(DECIM·DIFF_DELAY)); elaboration error otherwise.
- DECIM, 8: decimation ratio R (≥2); sets the o_last period.
- DIFF_DELAY, 1: comb differential delay M; used only in the width check.

Ports:
- i_clock  in  1  sole clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  NUM_CHAN·IN_WIDTH  lane c at bits [c·IN_WIDTH +: IN_WIDTH].
- i_valid  in  1  input sample strobe, all lanes together.
- i_clear  in  1  synchronous flush.
- o_data  out  NUM_CHAN·OUT_WIDTH  final-stage accumulators; lane c at [c·OUT_WIDTH +: OUT_WIDTH].
- o_valid  out  1  o_data holds a new sample this cycle.
- o_last  out  1  qualifies o_valid; marks the R-th output of each decimation group.

## Operation
- Lane input x is sign-extended to OUT_WIDTH.
- Valid pipeline: v[0] = i_valid; v[k] is registered from v[k-1], for k = 1..N.
- Stage 1: if v[0], acc1 <= acc1 + sext(x).
- Stage k (k ≥ 2): if v[k-1], acck <= acck + acc(k-1). This uses the registered output of stage k-1.
- All arithmetic is modulo 2^OUT_WIDTH. Wrap-around is intentional: no saturation and no overflow flag. The comb section recovers the correct result.
- Lanes are fully independent and share only the valid/phase control.
- Accumulators hold their value when their enable is low, so gaps in i_valid are transparent.
- o_data = accN for each lane. o_valid = v[N].
- Phase counter: range 0..DECIM-1. It increments on each o_valid and wraps DECIM-1 → 0. o_last = o_valid && (phase == DECIM-1).
- i_clear (priority over everything except reset) zeroes, on the next edge:
  - all accumulators,
  - all v[k],
  - the phase counter.
  - The i_valid sample presented in the i_clear cycle is dropped.
- Reset (i_reset_n low, asynchronous, any time including mid-stream) has the same effect as i_clear, applied immediately. Release is synchronous to usage; the first valid sample may be presented on the first edge after deassertion.

## Timing
- Reset values: o_data = 0, o_valid = 0, o_last = 0, phase = 0, all accumulators 0.
- Latency: the sample accepted at edge t contributes to o_data with o_valid high in the cycle after edge t+N-1, i.e. N cycles from i_valid to o_valid.
- Throughput: one sample per clock per lane. No backpressure; the consumer must accept every o_valid.
- i_clear asserted at edge t:
  - o_valid = 0 from t until new samples traverse the pipeline;
  - samples already in flight are discarded;
  - the first sample after clear produces o_last only on its DECIM-th output.
- Simultaneous i_valid and i_clear: clear wins; the sample is lost.
- Critical path: one OUT_WIDTH adder per stage. No multi-stage combinational chain is permitted.

## Test plan
- Impulse, N=4, 2 lanes, x=1 on lane 0 for one cycle, then zeros with i_valid held high → lane 0 o_data follows C(n+3,3): 1,4,10,20,35; lane 1 stays 0; first o_valid exactly 4 cycles after input.
- Step, N=2, x=1 continuous → o_data 1,3,6,10,15; o_last high on outputs 8,16,24 with DECIM=8.
- Gapped valid: same step, i_valid toggling 1,0,1,0 → identical o_data sequence, o_valid pattern delayed by N; values unchanged across gaps.
- Wrap/negative: OUT_WIDTH=20, x=−32768 continuous, N=1 → accumulator wraps modulo 2^20 (after 32 samples reads 0x00000 pattern as computed); downstream model matches bit-exactly.
- Mid-stream i_clear after 5 samples → next cycle all o_data = 0, o_valid = 0; restart step reproduces 1,3,6…; phase restarts (o_last on 8th new output).
- Async reset asserted between clock edges mid-stream → outputs 0 immediately without a clock edge; recovery identical to the cold-start step test.

Source files
------------

// File: rtl/cic_decim_integrator_cascade.sv
// Integrator half of a CIC decimator: NUM_STAGES cascaded accumulators per lane,
// a valid pipeline that skews with the stages, and a decimation-phase tag on the output.
module cic_decim_integrator_cascade #(
  parameter int NUM_CHAN   = 2,
  parameter int NUM_STAGES = 4,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 40,
  parameter int DECIM      = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NUM_CHAN*IN_WIDTH-1:0]  i_data,
  input  logic                          i_valid,
  input  logic                          i_clear,
  output logic [NUM_CHAN*OUT_WIDTH-1:0] o_data,
  output logic                          o_valid,
  output logic                          o_last
);

  localparam int GROWTH  = NUM_STAGES * $clog2(DECIM * DIFF_DELAY);
  localparam int PHASE_W = $clog2(DECIM);

  generate
    if (OUT_WIDTH < IN_WIDTH + GROWTH) begin : g_width_check
      $error("OUT_WIDTH too small for CIC bit growth");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_stage_check
      $error("NUM_STAGES must be in 1..8");
    end
    if (DECIM < 2) begin : g_decim_check
      $error("DECIM must be at least 2");
    end
  endgenerate

  // r_valid[s] is the enable seen by stage s+1; w_en[s] is the enable of stage s
  logic [NUM_STAGES-1:0] r_valid;
  logic [NUM_STAGES-1:0] w_en;
  logic [OUT_WIDTH-1:0]  r_acc    [NUM_CHAN][NUM_STAGES];
  logic [OUT_WIDTH-1:0]  w_addend [NUM_CHAN][NUM_STAGES];
  logic [PHASE_W-1:0]    r_phase;

  always_comb begin
    w_en    = '0;
    w_en[0] = i_valid;
    for (int s = 1; s < NUM_STAGES; s++) begin
      w_en[s] = r_valid[s-1];
    end
  end

  // Each stage adds only the registered output of its predecessor: one adder deep
  always_comb begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      w_addend[c][0] = {{(OUT_WIDTH-IN_WIDTH){i_data[c*IN_WIDTH+IN_WIDTH-1]}},
                        i_data[c*IN_WIDTH +: IN_WIDTH]};
      for (int s = 1; s < NUM_STAGES; s++) begin
        w_addend[c][s] = r_acc[c][s-1];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
      r_phase <= '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          r_acc[c][s] <= '0;
        end
      end
    end else if (i_clear) begin
      r_valid <= '0;
      r_phase <= '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          r_acc[c][s] <= '0;
        end
      end
    end else begin
      r_valid <= w_en;
      for (int c = 0; c < NUM_CHAN; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (w_en[s]) begin
            r_acc[c][s] <= r_acc[c][s] + w_addend[c][s];
          end
        end
      end
      if (r_valid[NUM_STAGES-1]) begin
        r_phase <= (r_phase == PHASE_W'(DECIM-1)) ? '0 : r_phase + 1'b1;
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      o_data[c*OUT_WIDTH +: OUT_WIDTH] = r_acc[c][NUM_STAGES-1];
    end
    o_valid = r_valid[NUM_STAGES-1];
    o_last  = r_valid[NUM_STAGES-1] && (r_phase == PHASE_W'(DECIM-1));
  end

endmodule
